// File: rtl/preamble_pkg.sv
// Shared types and constants for the preamble sequencer: state encoding,
// segment lengths and the packed {I,Q} sample format.
package preamble_pkg;

  localparam int STF_LEN  = 16;
  localparam int LTF_LEN  = 64;
  localparam int SAMPLE_W = 32;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } sample_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STF    = 3'd1,
    ST_LTF_GI = 3'd2,
    ST_LTF1   = 3'd3,
    ST_LTF2   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Halve both components, keeping the sign (rounds toward minus infinity).
  function automatic sample_t halve_sample(input sample_t s);
    sample_t r;
    r.i = s.i >>> 1;
    r.q = s.q >>> 1;
    return r;
  endfunction

endpackage

// File: rtl/preamble_window.sv
// Optional soft-start window: halves I and Q of the flagged sample.
// Only instantiated when PREAMBLE_WINDOW_EN is defined.
module preamble_window
  import preamble_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                halve_en,
  output logic [SAMPLE_W-1:0] sample_out
);

  always_comb begin
    sample_out = sample_in;
    if (halve_en) begin
      sample_out = halve_sample(sample_t'(sample_in));
    end
  end

endmodule

// File: rtl/preamble_seq_ctrl.sv
// Preamble sequencer: streams STF repetitions, LTF guard interval and two LTF
// symbols from external ROMs. Define PREAMBLE_WINDOW_EN to halve the first STF
// and first LTF guard-interval samples.
module preamble_seq_ctrl
  import preamble_pkg::*;
#(
  parameter int STF_REPS   = 10,
  parameter int LTF_GI_LEN = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  stf_addr,
  input  logic [31:0] stf_dout,
  output logic [5:0]  ltf_addr,
  input  logic [31:0] ltf_dout,
  output logic [31:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] STF_LAST = 16'(STF_LEN * STF_REPS - 1);
  localparam logic [15:0] GI_LAST  = 16'(LTF_GI_LEN - 1);
  localparam logic [15:0] LTF_LAST = 16'(LTF_LEN - 1);
  localparam logic [5:0]  GI_START = 6'(LTF_LEN - LTF_GI_LEN);

  state_e      state_q, state_d;
  logic [3:0]  stf_addr_q, stf_addr_d;
  logic [5:0]  ltf_addr_q, ltf_addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        drain_q, drain_d;
  logic        valid_q, valid_d;
  logic [31:0] sample_q, sample_d;

  logic        fetching;
  logic        load;
  logic        xfer;
  logic [31:0] rom_sample;
  logic [31:0] shaped_sample;

  // Addresses always point at the next sample to fetch; drain_q marks that the
  // last sample is already in the output register and only needs to transfer.
  assign fetching   = (state_q == ST_STF || state_q == ST_LTF_GI ||
                       state_q == ST_LTF1 || state_q == ST_LTF2) && !drain_q;
  assign load       = fetching && (!valid_q || sample_ready);
  assign xfer       = valid_q && sample_ready;
  assign rom_sample = (state_q == ST_STF) ? stf_dout : ltf_dout;

`ifdef PREAMBLE_WINDOW_EN
  logic first_fetch;
  assign first_fetch = (cnt_q == 16'd0) && (state_q == ST_STF || state_q == ST_LTF_GI);

  preamble_window u_window (
    .sample_in  (rom_sample),
    .halve_en   (first_fetch),
    .sample_out (shaped_sample)
  );
`else
  assign shaped_sample = rom_sample;
`endif

  always_comb begin
    state_d    = state_q;
    stf_addr_d = stf_addr_q;
    ltf_addr_d = ltf_addr_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    valid_d    = valid_q;
    sample_d   = sample_q;

    if (load) begin
      sample_d = shaped_sample;
      valid_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_STF;
        end
      end
      ST_STF: begin
        if (load) begin
          if (cnt_q == STF_LAST) begin
            state_d    = ST_LTF_GI;
            cnt_d      = '0;
            stf_addr_d = '0;
            ltf_addr_d = GI_START;
          end else begin
            cnt_d      = cnt_q + 16'd1;
            stf_addr_d = stf_addr_q + 4'd1;
          end
        end
      end
      ST_LTF_GI: begin
        if (load) begin
          if (cnt_q == GI_LAST) begin
            state_d    = ST_LTF1;
            cnt_d      = '0;
            ltf_addr_d = '0;
          end else begin
            cnt_d      = cnt_q + 16'd1;
            ltf_addr_d = ltf_addr_q + 6'd1;
          end
        end
      end
      ST_LTF1: begin
        if (load) begin
          if (cnt_q == LTF_LAST) begin
            state_d    = ST_LTF2;
            cnt_d      = '0;
            ltf_addr_d = '0;
          end else begin
            cnt_d      = cnt_q + 16'd1;
            ltf_addr_d = ltf_addr_q + 6'd1;
          end
        end
      end
      ST_LTF2: begin
        if (load) begin
          if (cnt_q == LTF_LAST) begin
            drain_d    = 1'b1;
            cnt_d      = '0;
            ltf_addr_d = '0;
          end else begin
            cnt_d      = cnt_q + 16'd1;
            ltf_addr_d = ltf_addr_q + 6'd1;
          end
        end else if (drain_q && xfer) begin
          state_d = ST_DONE;
          valid_d = 1'b0;
          drain_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a transfer in the same cycle.
    if (abort && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      stf_addr_d = '0;
      ltf_addr_d = '0;
      cnt_d      = '0;
      drain_d    = 1'b0;
      valid_d    = 1'b0;
      sample_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      stf_addr_q <= '0;
      ltf_addr_q <= '0;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      valid_q    <= 1'b0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      stf_addr_q <= stf_addr_d;
      ltf_addr_q <= ltf_addr_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      valid_q    <= valid_d;
      sample_q   <= sample_d;
    end
  end

  assign stf_addr     = stf_addr_q;
  assign ltf_addr     = ltf_addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_preamble_seq_ctrl.sv
// Bench for preamble_seq_ctrl: default and small (STF_REPS=2, LTF_GI_LEN=16)
// instances, checked every cycle against a transfer-level model.
module tb_preamble_seq_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] start_v = '0;
  logic [1:0] abort_v = '0;
  logic [1:0] ready_v = '0;

  logic [1:0][3:0]  stf_addr_a;
  logic [1:0][5:0]  ltf_addr_a;
  logic [1:0][31:0] stf_dout_a;
  logic [1:0][31:0] ltf_dout_a;
  logic [1:0][31:0] sample_a;
  logic [1:0]       valid_a;
  logic [1:0]       busy_a;
  logic [1:0]       done_a;

  logic [31:0] stf_rom [16];
  logic [31:0] ltf_rom [64];
  int reps_u [2] = '{10, 2};
  int gi_u   [2] = '{32, 16};

`ifdef PREAMBLE_WINDOW_EN
  localparam logic [31:0] FIRST_S = 32'h0179_0179;
  localparam logic [31:0] GI0_S   = 32'h0200_fe00;
  localparam logic [31:0] GI1_S   = 32'h091a_c000;
`else
  localparam logic [31:0] FIRST_S = 32'h02f2_02f2;
  localparam logic [31:0] GI0_S   = 32'h0400_fc00;
  localparam logic [31:0] GI1_S   = 32'h1234_8000;
`endif
  localparam logic [31:0] SECOND_S = 32'hfbd6_0000;

  always #5 clock = ~clock;

  preamble_seq_ctrl dut0 (
    .clock(clock), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .stf_addr(stf_addr_a[0]), .stf_dout(stf_dout_a[0]),
    .ltf_addr(ltf_addr_a[0]), .ltf_dout(ltf_dout_a[0]),
    .sample_out(sample_a[0]), .sample_valid(valid_a[0]), .sample_ready(ready_v[0]),
    .busy(busy_a[0]), .done(done_a[0])
  );

  preamble_seq_ctrl #(.STF_REPS(2), .LTF_GI_LEN(16)) dut1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .stf_addr(stf_addr_a[1]), .stf_dout(stf_dout_a[1]),
    .ltf_addr(ltf_addr_a[1]), .ltf_dout(ltf_dout_a[1]),
    .sample_out(sample_a[1]), .sample_valid(valid_a[1]), .sample_ready(ready_v[1]),
    .busy(busy_a[1]), .done(done_a[1])
  );

  assign stf_dout_a[0] = stf_rom[stf_addr_a[0]];
  assign stf_dout_a[1] = stf_rom[stf_addr_a[1]];
  assign ltf_dout_a[0] = ltf_rom[ltf_addr_a[0]];
  assign ltf_dout_a[1] = ltf_rom[ltf_addr_a[1]];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s u%0d: got %0h expected %0h at %0t", name, u, act, exp, $time);
  endtask

  function automatic logic [31:0] halve(input logic [31:0] s);
    logic signed [15:0] i;
    logic signed [15:0] q;
    i = s[31:16];
    q = s[15:0];
    i = i >>> 1;
    q = q >>> 1;
    return {i, q};
  endfunction

  function automatic int total_of(input int u);
    return 16 * reps_u[u] + gi_u[u] + 128;
  endfunction

  // Sample k of the preamble, straight from the segment layout.
  function automatic logic [31:0] exp_sample(input int u, input int k);
    int ns;
    logic [31:0] s;
    ns = 16 * reps_u[u];
    if (k < ns) s = stf_rom[4'(k % 16)];
    else if (k < ns + gi_u[u]) s = ltf_rom[6'(64 - gi_u[u] + (k - ns))];
    else s = ltf_rom[6'((k - ns - gi_u[u]) % 64)];
`ifdef PREAMBLE_WINDOW_EN
    if (k == 0 || k == ns) s = halve(s);
`endif
    return s;
  endfunction

  // Model phases: 0 idle, 1 first fetch, 2 streaming sample m_idx, 3 done cycle.
  int m_phase [2] = '{0, 0};
  int m_idx   [2] = '{0, 0};
  bit m_zero  [2] = '{1'b1, 1'b1};
  bit chk_en = 1'b0;

  int xcount [2] = '{0, 0};
  int vcount [2] = '{0, 0};
  int dcount [2] = '{0, 0};
  logic [31:0] rec0 [2];
  logic [31:0] rec1 [2];
  logic [31:0] rec_gi [2];
  bit stalled [2] = '{1'b0, 1'b0};
  logic [31:0] prev_s [2];

  always @(negedge clock) begin : mon
    int tot, ns, fi;
    for (int u = 0; u < 2; u++) begin
      tot = total_of(u);
      ns  = 16 * reps_u[u];
      if (chk_en) begin
        check("valid", u, 32'(valid_a[u]), 32'(m_phase[u] == 2));
        check("busy", u, 32'(busy_a[u]), 32'(m_phase[u] == 1 || m_phase[u] == 2));
        check("done", u, 32'(done_a[u]), 32'(m_phase[u] == 3));
        if (m_phase[u] == 2) check("sample", u, sample_a[u], exp_sample(u, m_idx[u]));
        if (m_phase[u] == 0) begin
          check("idle stf_addr", u, 32'(stf_addr_a[u]), 32'd0);
          check("idle ltf_addr", u, 32'(ltf_addr_a[u]), 32'd0);
          if (m_zero[u]) check("reset sample", u, sample_a[u], 32'd0);
        end
        if (stalled[u] && valid_a[u]) check("stall hold", u, sample_a[u], prev_s[u]);
        fi = (m_phase[u] == 1) ? 0 : m_idx[u] + 1;
        if ((m_phase[u] == 1 || m_phase[u] == 2) && fi < tot) begin
          if (fi < ns) check("stf_addr", u, 32'(stf_addr_a[u]), 32'(fi % 16));
          else if (fi < ns + gi_u[u]) check("gi ltf_addr", u, 32'(ltf_addr_a[u]), 32'(64 - gi_u[u] + fi - ns));
          else check("ltf_addr", u, 32'(ltf_addr_a[u]), 32'((fi - ns - gi_u[u]) % 64));
        end
      end
      stalled[u] = valid_a[u] && !ready_v[u];
      prev_s[u]  = sample_a[u];
      if (valid_a[u]) vcount[u]++;
      if (valid_a[u] && ready_v[u]) begin
        if (xcount[u] == 0)  rec0[u]   = sample_a[u];
        if (xcount[u] == 1)  rec1[u]   = sample_a[u];
        if (xcount[u] == ns) rec_gi[u] = sample_a[u];
        xcount[u]++;
      end
      if (done_a[u]) dcount[u]++;
      // advance the model with the inputs the next rising edge will see
      if (reset) begin
        m_phase[u] = 0; m_idx[u] = 0; m_zero[u] = 1'b1;
      end else if (abort_v[u] && m_phase[u] != 0) begin
        m_phase[u] = 0; m_idx[u] = 0;
      end else begin
        case (m_phase[u])
          0: if (start_v[u] && !abort_v[u]) begin m_phase[u] = 1; m_idx[u] = 0; m_zero[u] = 1'b0; end
          1: m_phase[u] = 2;
          2: if (ready_v[u]) begin
               if (m_idx[u] == tot - 1) m_phase[u] = 3;
               else m_idx[u]++;
             end
          default: m_phase[u] = 0;
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    for (int u = 0; u < 2; u++) begin
      xcount[u] = 0; vcount[u] = 0; dcount[u] = 0;
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    start_v = m;
    cyc();
    start_v = '0;
  endtask

  task automatic run_until_done(input logic [1:0] m, input bit rnd, input int budget);
    int c;
    c = 0;
    while (((m[0] && dcount[0] == 0) || (m[1] && dcount[1] == 0)) && c < budget) begin
      if (rnd) ready_v = 2'($urandom);
      cyc();
      c++;
    end
    ready_v = 2'b11;
    check("done within budget", 0, 32'(c < budget), 32'd1);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int c;
    c = 0;
    while (xcount[0] < n && c < budget) begin
      cyc();
      c++;
    end
    check("transfers within budget", 0, 32'(c < budget), 32'd1);
  endtask

  initial begin : stim
    for (int i = 0; i < 16; i++) stf_rom[i] = $urandom;
    for (int i = 0; i < 64; i++) ltf_rom[i] = $urandom;
    stf_rom[0]  = 32'h02f2_02f2;
    stf_rom[1]  = 32'hfbd6_0000;
    ltf_rom[32] = 32'h0400_fc00;
    ltf_rom[48] = 32'h1234_8000;

    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    cyc();

    // full preamble on both instances with ready held high
    clear_counts();
    ready_v = 2'b11;
    pulse_start(2'b11);
    run_until_done(2'b11, 1'b0, 1000);
    cyc();
    check("valid cycles", 0, 32'(vcount[0]), 32'd320);
    check("valid cycles", 1, 32'(vcount[1]), 32'd176);
    check("done pulses", 0, 32'(dcount[0]), 32'd1);
    check("done pulses", 1, 32'(dcount[1]), 32'd1);
    check("first sample", 0, rec0[0], FIRST_S);
    check("first sample", 1, rec0[1], FIRST_S);
    check("second sample", 0, rec1[0], SECOND_S);
    check("first gi sample", 0, rec_gi[0], GI0_S);
    check("first gi sample", 1, rec_gi[1], GI1_S);

    // random backpressure
    clear_counts();
    ready_v = 2'($urandom);
    pulse_start(2'b11);
    run_until_done(2'b11, 1'b1, 4000);
    cyc();
    check("transfers", 0, 32'(xcount[0]), 32'd320);
    check("transfers", 1, 32'(xcount[1]), 32'd176);
    check("done pulses rnd", 0, 32'(dcount[0]), 32'd1);
    check("done pulses rnd", 1, 32'(dcount[1]), 32'd1);

    // abort around sample 100, then restart
    clear_counts();
    ready_v = 2'b11;
    pulse_start(2'b01);
    wait_xfers(100, 500);
    abort_v = 2'b01;
    cyc();
    abort_v = '0;
    check("valid after abort", 0, 32'(valid_a[0]), 32'd0);
    check("busy after abort", 0, 32'(busy_a[0]), 32'd0);
    repeat (5) cyc();
    check("no done after abort", 0, 32'(dcount[0]), 32'd0);
    clear_counts();
    pulse_start(2'b01);
    run_until_done(2'b01, 1'b1, 4000);
    cyc();
    check("restart first sample", 0, rec0[0], FIRST_S);
    check("restart transfers", 0, 32'(xcount[0]), 32'd320);

    // start and abort together while idle: start must be dropped
    start_v = 2'b01;
    abort_v = 2'b01;
    cyc();
    start_v = '0;
    abort_v = '0;
    cyc();
    check("start with abort ignored", 0, 32'(busy_a[0]), 32'd0);

    // start while busy is ignored; reset at sample 200 discards the preamble
    clear_counts();
    ready_v = 2'b11;
    pulse_start(2'b01);
    start_v = 2'b01;
    repeat (20) cyc();
    start_v = '0;
    wait_xfers(200, 500);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    check("no done after reset", 0, 32'(dcount[0]), 32'd0);
    check("reset sample_out", 0, sample_a[0], 32'd0);
    check("reset valid", 0, 32'(valid_a[0]), 32'd0);
    check("reset busy", 0, 32'(busy_a[0]), 32'd0);
    check("reset stf_addr", 0, 32'(stf_addr_a[0]), 32'd0);
    check("reset ltf_addr", 0, 32'(ltf_addr_a[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
